// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-index/data widths, zero-register index and writeback entry record
package riscv_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: lookup idx_i over age-ordered entries (ent_i/vld_i, index 0 oldest) and output register (out_i/out_vld_i) -> hit_o/data_o, youngest match wins
module fwd_match
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [REG_IDX_W-1:0] idx_i,
  input  wb_entry_t            ent_i [DEPTH],
  input  logic [DEPTH-1:0]     vld_i,
  input  logic                 out_vld_i,
  input  wb_entry_t            out_i,
  output logic                 hit_o,
  output logic [XLEN-1:0]      data_o
);
  logic live;
  assign live = idx_i != REG_ZERO;
  always_comb begin
    hit_o = live && out_vld_i && out_i.rd == idx_i;
    data_o = hit_o ? out_i.data : '0;
    for (int i = 0; i < DEPTH; i++)
      if (live && vld_i[i] && ent_i[i].rd == idx_i) begin
        hit_o = 1'b1;
        data_o = ent_i[i].data;
      end
  end
endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: FIFO of pending results (inValid/inRd/inData/inReady) drained to the register-file write port (writePort/wBus/regWrite, held by wbStall) with two forwarding lookups (readPortN -> fwdHitN/fwdDataN)
module writeback_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inValid,
  input  logic [REG_IDX_W-1:0]       inRd,
  input  logic [XLEN-1:0]            inData,
  output logic                       inReady,
  input  logic                       wbStall,
  output logic [REG_IDX_W-1:0]       writePort,
  output logic [XLEN-1:0]            wBus,
  output logic                       regWrite,
  input  logic [REG_IDX_W-1:0]       readPort1,
  input  logic [REG_IDX_W-1:0]       readPort2,
  output logic                       fwdHit1,
  output logic                       fwdHit2,
  output logic [XLEN-1:0]            fwdData1,
  output logic [XLEN-1:0]            fwdData2,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t mem_q [DEPTH];
  wb_entry_t out_q, out_d;
  wb_entry_t ord [DEPTH];
  logic [DEPTH-1:0] ord_v;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic rw_q, rw_d, push, pop;
  assign inReady = count_q != CW'(DEPTH);
  assign push = inValid && inReady && inRd != REG_ZERO;
  assign pop = count_q != '0 && !wbStall;
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    rw_d = pop;
    out_d = pop ? mem_q[rd_ptr_q] : out_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rw_q <= 1'b0;
      out_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= '{rd: inRd, data: inData};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rw_q <= rw_d;
      out_q <= out_d;
    end
  end
  // Rotate storage so index 0 is the oldest live entry; the matcher then lets later indices win.
  always_comb
    for (int i = 0; i < DEPTH; i++) begin
      ord[i] = mem_q[rd_ptr_q + PW'(i)];
      ord_v[i] = CW'(i) < count_q;
    end
  fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .idx_i(readPort1), .ent_i(ord), .vld_i(ord_v), .out_vld_i(rw_q), .out_i(out_q),
    .hit_o(fwdHit1), .data_o(fwdData1)
  );
  fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .idx_i(readPort2), .ent_i(ord), .vld_i(ord_v), .out_vld_i(rw_q), .out_i(out_q),
    .hit_o(fwdHit2), .data_o(fwdData2)
  );
  assign writePort = out_q.rd;
  assign wBus = out_q.data;
  assign regWrite = rw_q;
  assign count = count_q;
endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of pending-write entries (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port inValid, input, 1, meaning a result is offered.
REQ-005 SHALL have port inRd, input, 5, the destination register of the offered result.
REQ-006 SHALL have port inData, input, 32, the result value.
REQ-007 SHALL have port inReady, output, 1, meaning the buffer can accept a result this cycle.
REQ-008 SHALL have port wbStall, input, 1, which holds the drain.
REQ-009 SHALL have port writePort, output, 5, the register-file write index.
REQ-010 SHALL have port wBus, output, 32, the register-file write data.
REQ-011 SHALL have port regWrite, output, 1, the register-file write enable.
REQ-012 SHALL have ports readPort1 and readPort2, input, 5 each, the forwarding lookup indices.
REQ-013 SHALL have ports fwdHit1 and fwdHit2, output, 1 each, meaning a pending write matches the lookup.
REQ-014 SHALL have ports fwdData1 and fwdData2, output, 32 each, the forwarded value.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits, the current FIFO occupancy.

Function
REQ-016 SHALL drive inReady = (count != DEPTH); there is no same-cycle pass-through when full.
REQ-017 SHALL accept a result on an edge where inValid && inReady.
REQ-018 SHALL enqueue an accepted result at the tail when inRd != 0; an accepted result with inRd == 0 SHALL be dropped, with no enqueue and no regWrite.
REQ-019 SHALL pop the head entry on each edge where the FIFO is non-empty and wbStall == 0, load the head's rd into writePort and its data into wBus, and set regWrite = 1.
REQ-020 SHALL clear regWrite to 0 on any edge with no pop; writePort and wBus SHALL then hold their previous values.
REQ-021 SHALL produce regWrite high for the first time during the cycle after the second edge following acceptance, when the FIFO is empty and there is no stall (latency 2).
REQ-022 SHALL allow push and pop on the same edge; count is then unchanged and order is preserved (strict FIFO).
REQ-023 SHALL let read and write pointers wrap modulo DEPTH; full and empty SHALL be derived from count, not from pointer equality alone.
REQ-024 SHALL, for lookup port n: if readPortN == 0 then fwdHitN = 0 and fwdDataN = 0.
REQ-025 SHALL, for lookup port n, otherwise search the valid FIFO entries youngest-first and return the youngest match.
REQ-026 SHALL, for lookup port n, fall back to the output register (writePort/wBus while regWrite == 1) when no FIFO entry matches.
REQ-027 SHALL set fwdHitN = 0 and fwdDataN = 0 when nothing matches.
REQ-028 SHALL implement the lookups combinationally.
REQ-029 SHALL NOT let the same-cycle incoming inData participate in forwarding.
REQ-030 SHALL keep count and regWrite consistent with each other; the number of regWrite pulses SHALL equal the number of enqueues.

Reset
REQ-031 SHALL, when reset == 1 at an edge, set count = 0, clear both pointers, set regWrite = 0, writePort = 0 and wBus = 0, and invalidate all entries.
REQ-032 SHALL discard any entries pending when reset is applied mid-operation, with no regWrite pulse afterwards.
REQ-033 SHALL give reset priority over push and pop on the same edge.
REQ-034 SHALL have fwdHit1/2 = 0 on the cycle after reset.

Structure
REQ-035 SHALL take REG_IDX_W = 5, XLEN = 32 and the zero-register index constant from the shared riscv package.
REQ-036 SHALL place the entry record type (rd, data) in that package.
REQ-037 SHALL instantiate one sub-module, fwd_match, once per lookup port; it performs the priority search over entries plus the output register.
REQ-038 SHALL contain no register-file storage; it drives the existing register bank write port only.

Verification
REQ-039 Single write: push rd=5, data=0xDEADBEEF into an empty buffer -> regWrite=1, writePort=5, wBus=0xDEADBEEF exactly 2 edges later, then regWrite=0.
REQ-040 Full/backpressure: wbStall=1, push 4 entries -> inReady=0 and count=4; a 5th push is ignored; release the stall -> 4 in-order writes on consecutive cycles.
REQ-041 Forwarding priority: queue rd=3/0x11 then rd=3/0x22, readPort1=3 -> fwdHit1=1, fwdData1=0x22; readPort2=0 -> fwdHit2=0.
REQ-042 x0 drop: push rd=0, data=0xFFFFFFFF -> count stays 0 and no regWrite occurs.
REQ-043 Simultaneous push/pop at count=2 -> count stays 2 and order is preserved across pointer wrap-around after 10 operations.
REQ-044 Mid-operation reset with 3 entries pending -> count=0, regWrite=0 and no later writes.
